// File: rtl/multdiv_pkg.sv
// multdiv_pkg: FSM state encoding and default exception constants for multdiv_issue_ctrl
package multdiv_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, DONE = 2'd3} md_state_t;
    localparam int          DEF_TIMEOUT_CYCLES = 40;
    localparam logic [4:0]  DEF_EXC_REG        = 5'd30;
    localparam logic [31:0] DEF_RSTATUS_MULT   = 32'd4;
    localparam logic [31:0] DEF_RSTATUS_DIV    = 32'd5;
endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// multdiv_issue_ctrl_if: execute-stage request, multdiv unit bus, stall and writeback beat; master=controller, slave=pipeline/unit side
interface multdiv_issue_ctrl_if;
    logic        ex_valid, ex_is_mult, ex_is_div, flush;
    logic [4:0]  ex_rd;
    logic [31:0] ex_opA, ex_opB;
    logic [31:0] md_operandA, md_operandB, md_result;
    logic        md_ctrl_MULT, md_ctrl_DIV, md_exception, md_resultRDY;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    modport master(
        input  ex_valid, ex_is_mult, ex_is_div, ex_rd, ex_opA, ex_opB, flush, md_result, md_exception, md_resultRDY,
        output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV, stall, wb_valid, wb_rd, wb_data
    );
    modport slave(
        output ex_valid, ex_is_mult, ex_is_div, ex_rd, ex_opA, ex_opB, flush, md_result, md_exception, md_resultRDY,
        input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV, stall, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/md_timeout_counter.sv
// md_timeout_counter: 6-bit wait counter with sync clear, enable and terminal-count flag at LIMIT-1; ports clock, reset, clr, en -> tc
module md_timeout_counter #(parameter int LIMIT = 40) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [5:0] cnt;
    always_ff @(posedge clock)
        cnt <= (reset || clr) ? '0 : en ? cnt + 6'd1 : cnt;
    assign tc = cnt == 6'(LIMIT - 1);
endmodule

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: issues one mult/div to the multdiv unit, stalls until ready or timeout, then emits one writeback beat; ports clock, reset, bus (multdiv_issue_ctrl_if.master)
module multdiv_issue_ctrl
    import multdiv_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [4:0]  EXC_REG        = DEF_EXC_REG,
    parameter logic [31:0] RSTATUS_MULT   = DEF_RSTATUS_MULT,
    parameter logic [31:0] RSTATUS_DIV    = DEF_RSTATUS_DIV
) (
    input logic                   clock,
    input logic                   reset,
    multdiv_issue_ctrl_if.master  bus
);
    md_state_t   state, state_nx;
    logic [31:0] op_a, op_b, res_q;
    logic [4:0]  rd_q;
    logic        is_div_q, exc_q, accept, tc;
    assign accept = bus.ex_valid && (bus.ex_is_mult || bus.ex_is_div) && !bus.flush;
    md_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clock (clock),
        .reset (reset),
        .clr   (state != WAIT),
        .en    (state == WAIT),
        .tc    (tc)
    );
    always_comb begin
        state_nx         = IDLE;
        bus.md_operandA  = op_a;
        bus.md_operandB  = op_b;
        bus.md_ctrl_MULT = state == START && !is_div_q;
        bus.md_ctrl_DIV  = state == START && is_div_q;
        bus.stall        = state == START || state == WAIT || (state == IDLE && accept);
        bus.wb_valid     = state == DONE && !bus.flush && (exc_q || rd_q != '0);
        bus.wb_rd        = state != DONE ? '0 : exc_q ? EXC_REG : rd_q;
        bus.wb_data      = state != DONE ? '0 : exc_q ? (is_div_q ? RSTATUS_DIV : RSTATUS_MULT) : res_q;
        if (!bus.flush)
            case (state)
                IDLE:    state_nx = accept ? START : IDLE;
                START:   state_nx = WAIT;
                WAIT:    state_nx = (bus.md_resultRDY || tc) ? DONE : WAIT;
                default: state_nx = IDLE;
            endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            res_q    <= '0;
            rd_q     <= '0;
            is_div_q <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && accept) begin
                op_a     <= bus.ex_opA;
                op_b     <= bus.ex_opB;
                rd_q     <= bus.ex_rd;
                is_div_q <= !bus.ex_is_mult;
                exc_q    <= 1'b0;
            end
            if (state == WAIT && !bus.flush) begin
                if (bus.md_resultRDY) begin
                    res_q <= bus.md_result;
                    exc_q <= bus.md_exception;
                end else if (tc)
                    exc_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb_multdiv_issue_ctrl: directed plus randomized checks of multdiv_issue_ctrl against a cycle-count/result model
module tb_multdiv_issue_ctrl;
    import multdiv_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    multdiv_issue_ctrl_if bus();
    multdiv_issue_ctrl dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.ex_valid = 0; bus.ex_is_mult = 0; bus.ex_is_div = 0; bus.ex_rd = 0;
        bus.ex_opA = 0; bus.ex_opB = 0; bus.flush = 0;
        bus.md_result = 0; bus.md_exception = 0; bus.md_resultRDY = 0;
    endtask

    task automatic drive_op(input bit m, input bit dv, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        bus.ex_valid = 1; bus.ex_is_mult = m; bus.ex_is_div = dv; bus.ex_rd = rd;
        bus.ex_opA = a; bus.ex_opB = b; bus.flush = 0;
    endtask

    task automatic idle_check();
        @(negedge clock);
        drive_idle();
        #1;
        chk("idle_stall", bus.stall, 0);
        chk("idle_wb_valid", bus.wb_valid, 0);
        chk("idle_strobe", {bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 0);
    endtask

    // lat: unit ready lat cycles after the strobe cycle; 0 means the unit never answers
    task automatic run_op(input bit m, input bit dv, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input bit exc, input logic [31:0] res, input bit stale);
        bit          timed_out = !(lat >= 1 && lat <= DEF_TIMEOUT_CYCLES);
        bit          use_div   = !m;
        bit          redirect  = timed_out || exc;
        bit          writes    = redirect || rd != 5'd0;
        int          done_at   = 2 + (timed_out ? DEF_TIMEOUT_CYCLES : lat);
        logic [31:0] exp_data  = redirect ? (use_div ? 32'd5 : 32'd4) : res;
        logic [4:0]  exp_rd    = redirect ? 5'd30 : rd;
        int          stalls = 0, mults = 0, divs = 0, wbs = 0, strobe_at = -1;
        bit          done = 0;
        @(negedge clock);
        drive_op(m, dv, rd, a, b);
        bus.md_resultRDY = stale;
        bus.md_exception = 0;
        bus.md_result    = 32'hdead_beef;
        #1;
        chk("accept_stall", bus.stall, 1);
        chk("accept_no_strobe", {bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 0);
        for (int i = 1; i <= 100 && !done; i++) begin
            @(negedge clock);
            bus.md_resultRDY = (stale && i == 1) || (!timed_out && i == 1 + lat);
            bus.md_exception = exc && i == 1 + lat;
            bus.md_result    = (i == 1 + lat) ? res : 32'hdead_beef;
            #1;
            stalls += int'(bus.stall);
            mults  += int'(bus.md_ctrl_MULT);
            divs   += int'(bus.md_ctrl_DIV);
            wbs    += int'(bus.wb_valid);
            if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) begin
                strobe_at = i;
                chk("operandA", bus.md_operandA, a);
                chk("operandB", bus.md_operandB, b);
            end
            if (!bus.stall) begin
                done = 1;
                chk("done_cycle", i, done_at);
                chk("wb_valid", bus.wb_valid, writes);
                if (writes) begin
                    chk("wb_rd", bus.wb_rd, exp_rd);
                    chk("wb_data", bus.wb_data, exp_data);
                end
            end
        end
        if (!done) chk("done_reached", 0, 1);
        chk("stall_cycles", stalls + 1, done_at);
        chk("mult_strobes", mults, use_div ? 0 : 1);
        chk("div_strobes", divs, use_div ? 1 : 0);
        chk("strobe_cycle", strobe_at, 1);
        chk("wb_pulses", wbs, writes);
        bus.md_resultRDY = 0;
        bus.md_exception = 0;
    endtask

    // flush arrives in WAIT cycle f; a late ready afterwards must be ignored
    task automatic run_flush(input bit m, input logic [4:0] rd, input int f);
        @(negedge clock);
        drive_op(m, !m, rd, 32'h11, 32'h22);
        for (int i = 1; i <= f + 1; i++) @(negedge clock);
        bus.flush = 1;
        #1;
        chk("flush_no_wb", bus.wb_valid, 0);
        @(negedge clock);
        drive_idle();
        bus.md_resultRDY = 1;
        bus.md_result    = 32'h1234;
        #1;
        chk("flush_stall", bus.stall, 0);
        chk("flush_wb", bus.wb_valid, 0);
        @(negedge clock);
        #1;
        chk("flush_late_ready_wb", bus.wb_valid, 0);
        chk("flush_late_ready_stall", bus.stall, 0);
        bus.md_resultRDY = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_opA"}, bus.md_operandA, 0);
        chk({tag, "_opB"}, bus.md_operandB, 0);
        chk({tag, "_strobes"}, {bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 0);
        chk({tag, "_stall"}, bus.stall, 0);
        chk({tag, "_wb_valid"}, bus.wb_valid, 0);
        chk({tag, "_wb_rd"}, bus.wb_rd, 0);
        chk({tag, "_wb_data"}, bus.wb_data, 0);
    endtask

    task automatic run_reset(input int k);
        @(negedge clock);
        drive_op(1, 0, 5'd12, 32'hcafe, 32'hbeef);
        for (int i = 1; i <= k + 1; i++) @(negedge clock);
        reset = 1;
        drive_idle();
        @(posedge clock);
        #1;
        check_all_zero("mid_reset");
        @(negedge clock);
        reset = 0;
    endtask

    initial begin
        drive_idle();
        repeat (2) @(negedge clock);
        #1;
        check_all_zero("reset");
        reset = 0;
        @(negedge clock);
        bus.ex_valid = 1;
        #1;
        chk("non_md_stall", bus.stall, 0);
        @(negedge clock);
        bus.ex_is_mult = 1;
        bus.flush = 1;
        #1;
        chk("flush_blocks_accept", bus.stall, 0);
        idle_check();
        run_op(1, 0, 5'd5, 32'd7, 32'd6, 33, 0, 32'd42, 0);
        idle_check();
        run_op(0, 1, 5'd9, 32'd100, 32'd0, 10, 1, 32'd0, 0);
        idle_check();
        run_op(1, 0, 5'd3, 32'd9, 32'd9, 5, 0, 32'd81, 1);
        idle_check();
        run_op(1, 0, 5'd7, 32'd1, 32'd2, 0, 0, 32'd0, 0);
        idle_check();
        run_op(0, 1, 5'd0, 32'd8, 32'd2, 4, 0, 32'd4, 0);
        idle_check();
        run_op(1, 1, 5'd4, 32'd3, 32'd5, 2, 0, 32'd15, 0);
        idle_check();
        run_op(0, 1, 5'd6, 32'd50, 32'd5, 40, 0, 32'd10, 0);
        idle_check();
        run_op(0, 1, 5'd6, 32'd50, 32'd5, 41, 0, 32'd10, 0);
        idle_check();
        run_flush(1, 5'd8, 5);
        run_op(0, 1, 5'd10, 32'd81, 32'd9, 20, 0, 32'd9, 0);
        idle_check();
        run_reset(3);
        run_op(1, 0, 5'd11, 32'd12, 32'd12, 3, 0, 32'd144, 0);
        run_op(0, 1, 5'd13, 32'd144, 32'd12, 6, 0, 32'd12, 0);
        idle_check();
        for (int n = 0; n < 25; n++) begin
            bit          m   = 1'($urandom_range(0, 1));
            bit          dv  = m ? 1'($urandom_range(0, 1)) : 1'b1;
            logic [4:0]  rd  = 5'($urandom_range(0, 31));
            logic [31:0] a   = $urandom;
            logic [31:0] b   = $urandom;
            int          lat = int'($urandom_range(0, 45));
            bit          exc = $urandom_range(0, 3) == 0;
            bit          stl = 1'($urandom_range(0, 1));
            run_op(m, dv, rd, a, b, lat, exc, m ? a * b : a ^ b, stl);
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
